// File: rtl/remote_link_arb.sv
// remote_link_arb: two-requester arbiter for a shared command/response FIFO pair.
// A requester is granted round-robin. It pushes CMD_BYTES command bytes and
// then pops RSP_BYTES response bytes. It keeps the FIFO pair for that whole
// frame.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req[1:0]              per-requester transaction request
//   gnt[1:0]              registered one-hot grant
//   m_wr_en, m_din        requester command strobes / bytes (req i on [8i+7:8i])
//   m_full                per-requester command back-pressure
//   m_rd_en, m_dout       requester response strobes / shared response byte
//   m_empty               per-requester response-empty indication
//   abort                 one-cycle pulse when the watchdog kills a frame
//   full, wr_en, din      shared command FIFO side
//   empty, rd_en, dout    shared response FIFO side
//
// Optional build macro: REMOTE_LINK_ARB_TIMEOUT_EN enables the response-wait
// watchdog (TIMEOUT_CYCLES consecutive empty cycles in RSP). Without it, abort
// is tied low and RSP waits indefinitely.
//
// state | meaning
// IDLE  | no owner; arbitrate on req
// CMD   | owner pushes command bytes
// RSP   | owner pops response bytes

module remote_link_arb #(
  parameter int CMD_BYTES      = 8,
  parameter int RSP_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  m_wr_en,
  input  logic [15:0] m_din,
  output logic [1:0]  m_full,
  input  logic [1:0]  m_rd_en,
  output logic [7:0]  m_dout,
  output logic [1:0]  m_empty,
  output logic [1:0]  abort,
  input  logic        full,
  output logic        wr_en,
  output logic [7:0]  din,
  input  logic        empty,
  output logic        rd_en,
  input  logic [7:0]  dout
);

  localparam int MAXB = (CMD_BYTES > RSP_BYTES) ? CMD_BYTES : RSP_BYTES;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_BYTES - 1);
  localparam logic [CW-1:0] RSP_LAST = CW'(RSP_BYTES - 1);

  if (CMD_BYTES < 1 || RSP_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("remote_link_arb: CMD_BYTES, RSP_BYTES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            ptr_q, ptr_d;
  logic [CW-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [CW-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic            g;
  logic            in_cmd, in_rsp;
  logic            timeout;
  logic            sel;

  // The grant is one-hot, so bit 1 is the index of the owner.
  assign g      = gnt_q[1];
  assign gnt    = gnt_q;
  assign m_dout = dout;

  // Outputs come from registered state. They are forced idle while rst is
  // high, so nothing is pushed or popped during a reset cycle.
  always_comb begin
    in_cmd  = ~rst & (state_q == S_CMD);
    in_rsp  = ~rst & (state_q == S_RSP);
    wr_en   = in_cmd & m_wr_en[g] & ~full;
    rd_en   = in_rsp & m_rd_en[g] & ~empty;
    din     = 8'h00;
    if (in_cmd) din = g ? m_din[15:8] : m_din[7:0];
    m_full  = 2'b11;
    if (in_cmd) m_full[g] = full;
    m_empty = 2'b11;
    if (in_rsp) m_empty[g] = empty;
  end

`ifdef REMOTE_LINK_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  // Counts consecutive empty cycles in RSP. The cycle that would reach
  // TIMEOUT_CYCLES fires the abort directly.
  always_comb begin
    wait_cnt_d = '0;
    timeout    = 1'b0;
    if (in_rsp) begin
      if (rd_en) begin
        wait_cnt_d = '0;
      end else if (empty) begin
        if (wait_cnt_q == WAIT_LAST) timeout = 1'b1;
        else                         wait_cnt_d = wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign abort = timeout ? gnt_q : 2'b00;
`else
  assign timeout = 1'b0;
  assign abort   = 2'b00;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cmd_cnt_d = cmd_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    sel       = req[ptr_q] ? ptr_q : ~ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d     = sel ? 2'b10 : 2'b01;
          state_d   = S_CMD;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
        end
      end
      S_CMD: begin
        if (wr_en) begin
          cmd_cnt_d = cmd_cnt_q + 1'b1;
          if (cmd_cnt_q == CMD_LAST) state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rd_en) rsp_cnt_d = rsp_cnt_q + 1'b1;
        if ((rd_en && rsp_cnt_q == RSP_LAST) || timeout) begin
          state_d   = S_IDLE;
          gnt_d     = 2'b00;
          ptr_d     = ~g;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      ptr_q     <= 1'b0;
      cmd_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cmd_cnt_q <= cmd_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

endmodule

// File: tb/tb_remote_link_arb.sv
module tb_remote_link_arb;

  localparam int CMD_BYTES      = 8;
  localparam int RSP_BYTES      = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  m_wr_en;
  logic [15:0] m_din;
  logic [1:0]  m_full;
  logic [1:0]  m_rd_en;
  logic [7:0]  m_dout;
  logic [1:0]  m_empty;
  logic [1:0]  abort;
  logic        full;
  logic        wr_en;
  logic [7:0]  din;
  logic        empty;
  logic        rd_en;
  logic [7:0]  dout;

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt = 0;
  int base;
  logic [1:0] ab;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) push_cnt <= push_cnt + 1;

  remote_link_arb #(
    .CMD_BYTES(CMD_BYTES), .RSP_BYTES(RSP_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .m_wr_en(m_wr_en), .m_din(m_din), .m_full(m_full),
    .m_rd_en(m_rd_en), .m_dout(m_dout), .m_empty(m_empty),
    .abort(abort),
    .full(full), .wr_en(wr_en), .din(din),
    .empty(empty), .rd_en(rd_en), .dout(dout)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame for an already-granted requester r. The other requester strobes too,
  // and those strobes must be ignored.
  task automatic xfer(input int r);
    logic [7:0] d;
    for (int k = 1; k <= CMD_BYTES; k++) begin
      d = {r[3:0], 4'(k)};
      m_wr_en = 2'b11;
      m_din = (r == 0) ? {8'hEE, d} : {d, 8'h55};
      #1;
      chk("cmd_wr_en", {15'd0, wr_en}, 16'd1);
      chk("cmd_din", {8'd0, din}, {8'd0, d});
      chk("cmd_m_full", {14'd0, m_full}, (r == 0) ? 16'd2 : 16'd1);
      tick();
    end
    m_wr_en = 2'b00;
    for (int k = 1; k <= RSP_BYTES; k++) begin
      m_rd_en = 2'b11;
      empty = 1'b0;
      dout = 8'hC0 | 8'(k);
      #1;
      chk("rsp_rd_en", {15'd0, rd_en}, 16'd1);
      chk("rsp_m_dout", {8'd0, m_dout}, {8'd0, 8'hC0 | 8'(k)});
      chk("rsp_m_empty", {14'd0, m_empty}, (r == 0) ? 16'd2 : 16'd1);
      tick();
    end
    m_rd_en = 2'b00;
    empty = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; m_wr_en = 2'b00; m_din = 16'h0000; m_rd_en = 2'b00;
    full = 1'b0; empty = 1'b1; dout = 8'h00;
    tick(); tick();
    m_wr_en = 2'b11;
    #1;
    chk("rst_gnt", {14'd0, gnt}, 16'd0);
    chk("rst_m_full", {14'd0, m_full}, 16'd3);
    chk("rst_m_empty", {14'd0, m_empty}, 16'd3);
    chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
    chk("rst_abort", {14'd0, abort}, 16'd0);
    m_wr_en = 2'b00;

    // single requester frame
    rst = 1'b0; req = 2'b01;
    #1 chk("gnt_before_edge", {14'd0, gnt}, 16'd0);
    tick();
    chk("gnt_single", {14'd0, gnt}, 16'd1);
    req = 2'b00;
    base = push_cnt;
    xfer(0);
    chk("gnt_single_done", {14'd0, gnt}, 16'd0);
    chk("single_push_cnt", 16'(push_cnt - base), 16'd8);

    // contention from reset: 0,1,0 with minimum turnaround
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11;
    tick();
    chk("cont_gnt1", {14'd0, gnt}, 16'd1);
    xfer(0);
    chk("cont_idle1", {14'd0, gnt}, 16'd0);
    tick();
    chk("cont_gnt2", {14'd0, gnt}, 16'd2);
    xfer(1);
    chk("cont_idle2", {14'd0, gnt}, 16'd0);
    tick();
    chk("cont_gnt3", {14'd0, gnt}, 16'd1);
    req = 2'b00;

    // back-pressure and ungranted strobes while requester 0 owns the pair
    base = push_cnt;
    for (int k = 1; k <= 3; k++) begin
      m_wr_en = 2'b01; m_din = {8'h77, 8'(k)};
      tick();
    end
    m_wr_en = 2'b10; m_din = {8'h99, 8'h03};
    #1;
    chk("ungnt_wr_en", {15'd0, wr_en}, 16'd0);
    chk("ungnt_din", {8'd0, din}, 16'h0003);
    tick();
    m_wr_en = 2'b01; full = 1'b1;
    ab = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      ab = ab | {1'b0, wr_en};
      if (i == 0) chk("full_m_full", {14'd0, m_full}, 16'd3);
      tick();
    end
    chk("full_no_push", {14'd0, ab}, 16'd0);
    chk("full_push_frozen", 16'(push_cnt - base), 16'd3);
    full = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      m_din = {8'h77, 8'(k)};
      #1 chk("bp_din", {8'd0, din}, {8'd0, 8'(k)});
      tick();
    end
    m_wr_en = 2'b00;
    chk("bp_push_total", 16'(push_cnt - base), 16'd8);
    empty = 1'b0;
    #1 chk("bp_in_rsp", {14'd0, m_empty}, 16'd2);

    // reset in RSP after three pops
    m_rd_en = 2'b01;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    #1 chk("rd_en_in_rst", {15'd0, rd_en}, 16'd0);
    tick();
    chk("rstmid_gnt", {14'd0, gnt}, 16'd0);
    chk("rstmid_state", {14'd0, dut.state_q}, 16'd0);
    chk("rstmid_ptr", {15'd0, dut.ptr_q}, 16'd0);
    rst = 1'b0; m_rd_en = 2'b00; empty = 1'b1;
    req = 2'b10;
    tick();
    chk("post_rst_gnt", {14'd0, gnt}, 16'd2);
    req = 2'b00;
    xfer(1);
    chk("post_rst_done", {14'd0, gnt}, 16'd0);

    // response starvation
    req = 2'b01;
    tick();
    req = 2'b00;
    for (int k = 1; k <= CMD_BYTES; k++) begin
      m_wr_en = 2'b01; m_din = {8'h00, 8'(k)};
      tick();
    end
    m_wr_en = 2'b00; m_rd_en = 2'b01; empty = 1'b1;
    ab = 2'b00;
    for (int i = 1; i <= TIMEOUT_CYCLES - 1; i++) begin
      #1 ab = ab | abort;
      tick();
    end
    chk("to_no_early_abort", {14'd0, ab}, 16'd0);
    #1;
`ifdef REMOTE_LINK_ARB_TIMEOUT_EN
    chk("to_abort_pulse", {14'd0, abort}, 16'd1);
    tick();
    chk("to_gnt_cleared", {14'd0, gnt}, 16'd0);
    chk("to_abort_one_cycle", {14'd0, abort}, 16'd0);
`else
    chk("to_abort_tied", {14'd0, abort}, 16'd0);
    tick();
    chk("to_gnt_held", {14'd0, gnt}, 16'd1);
`endif
    m_rd_en = 2'b00;
    rst = 1'b1; tick(); rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/remote_link_arb.md
REMOTE_LINK_ARB -- requirements
Module: remote_link_arb

Interface
REQ-001 Parameter CMD_BYTES, default 8, is the number of command bytes per transaction (address frame).
REQ-002 Parameter RSP_BYTES, default 8, is the number of response bytes per transaction (data frame).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, is the response-wait watchdog limit in cycles (used only with the macro in REQ-030).
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  2  per-requester transaction request, bit i = requester i.
REQ-007 gnt  out  2  one-hot grant, registered.
REQ-008 m_wr_en  in  2  requester command-byte write strobe.
REQ-009 m_din  in  16  requester command bytes; requester i on bits [8i+7:8i].
REQ-010 m_full  out  2  per-requester command back-pressure.
REQ-011 m_rd_en  in  2  requester response-byte read strobe.
REQ-012 m_dout  out  8  shared response byte, driven from dout.
REQ-013 m_empty  out  2  per-requester response-empty indication.
REQ-014 abort  out  2  one-cycle pulse: granted transaction killed by watchdog.
REQ-015 full  in  1  shared command FIFO full; wr_en  out  1  push; din  out  8  command byte.
REQ-016 empty  in  1  shared response FIFO empty; rd_en  out  1  pop; dout  in  8  response byte.

Function
REQ-017 FSM states IDLE, CMD, RSP; one requester owns the shared FIFO pair from grant until its last response byte.
REQ-018 IDLE: if req nonzero, grant the requester selected by round-robin pointer ptr (ptr's requester if it requests, else the other); gnt rises the cycle after req is sampled; state -> CMD, counters cleared.
REQ-019 CMD: wr_en = m_wr_en[g] & ~full; din = m_din[g]; cmd_cnt increments per accepted byte; after CMD_BYTES accepted, state -> RSP the next cycle.
REQ-020 RSP: rd_en = m_rd_en[g] & ~empty; m_dout = dout; rsp_cnt increments per pop; after RSP_BYTES popped, state -> IDLE, gnt cleared, ptr set to the other requester.
REQ-021 m_full[g] = full in CMD, 1 otherwise; m_empty[g] = empty in RSP, 1 otherwise; ungranted requester sees m_full=1, m_empty=1 always.
REQ-022 Strobes from ungranted requester, or wr_en while full, or rd_en while empty, are ignored and never counted.
REQ-023 Deassertion of req[g] mid-transaction is ignored; grant held until frame completes.
REQ-024 Simultaneous req=2'b11 in IDLE: ptr wins; back-to-back contention alternates 0,1,0,1.
REQ-025 Minimum turnaround: last response pop at cycle T, IDLE at T+1, next gnt at T+2.
REQ-026 Counters width $clog2(max(CMD_BYTES,RSP_BYTES))+1; no wrap within a transaction.

Reset
REQ-027 On rst: state IDLE, gnt=0, ptr=0, cmd_cnt=0, rsp_cnt=0, abort=0, wr_en=0, rd_en=0, m_full=2'b11, m_empty=2'b11.
REQ-028 Reset mid-transaction discards the transaction; FIFO contents are not touched by this block.
REQ-029 wr_en and rd_en are combinational from registered state and are 0 during reset.

Configuration
REQ-030 Macro REMOTE_LINK_ARB_TIMEOUT_EN defined: in RSP a wait counter counts consecutive cycles with empty=1, clears on any pop; reaching TIMEOUT_CYCLES pulses abort[g] one cycle and forces IDLE with ptr advanced.
REQ-031 Macro undefined: no wait counter is built, abort is tied 2'b00, RSP waits indefinitely.

Verification
REQ-032 req=2'b01, full=0, 8 command bytes 01..08 then 8 response bytes -> gnt=01 one cycle after req, din sequence 01..08, m_dout tracks dout, gnt=00 one cycle after 8th pop.
REQ-033 req=2'b11 from reset, three transactions -> grants 01,10,01; requester 1 stalled with m_full=1 during requester 0 ownership.
REQ-034 full=1 for 5 cycles mid-command with m_wr_en held -> wr_en=0, cmd_cnt frozen, exactly 8 bytes pushed overall.
REQ-035 rst asserted in RSP after 3 pops -> next cycle gnt=00, state IDLE, ptr=0; fresh req=2'b10 granted normally.
REQ-036 With REMOTE_LINK_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, empty stuck 1 in RSP -> abort[g] pulse on 16th empty cycle, gnt=00 next cycle; without macro abort stays 0 and gnt held.
REQ-037 m_wr_en from ungranted requester during CMD -> no wr_en, no din change, counters unchanged.
